// File: rtl/alu_ctrl_pkg.sv
// Shared types for the ALU sequencing controller: opcodes, instruction field layout,
// controller states and the instruction decode helper.
package alu_ctrl_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 2;
  localparam int NREG   = 4;

  // ins_word layout
  localparam int OPC_LSB  = 0;
  localparam int OPC_W    = 3;
  localparam int CIN_BIT  = 3;
  localparam int DST_LSB  = 4;
  localparam int SRCA_LSB = 6;
  localparam int SRCB_LSB = 8;
  localparam int REP_LSB  = 10;
  localparam int REP_W    = 4;
  localparam int RSV_LSB  = 14;
  localparam int RSV_W    = 2;

  typedef enum logic [OPC_W-1:0] {
    ADD     = 3'd0,
    ADDHALF = 3'd1,
    INC     = 3'd2,
    MUL15   = 3'd3,
    AND     = 3'd4,
    OR      = 3'd5,
    NOT     = 3'd6,
    ZERO    = 3'd7
  } opc_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Repeat count is kept out of this struct so the no-repeat build carries no counter bits.
  typedef struct packed {
    opc_e              opc;
    logic              cin;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] src_a;
    logic [ADDR_W-1:0] src_b;
  } ins_t;

  function automatic ins_t decode_ins(input logic [DATA_W-1:0] w);
    ins_t d;
    d.opc   = opc_e'(w[OPC_LSB +: OPC_W]);
    d.cin   = w[CIN_BIT];
    d.dst   = w[DST_LSB +: ADDR_W];
    d.src_a = w[SRCA_LSB +: ADDR_W];
    d.src_b = w[SRCB_LSB +: ADDR_W];
    return d;
  endfunction

endpackage

// File: rtl/alu_ctrl_rf.sv
// 4x16 register file: one synchronous write port, three combinational read ports,
// asynchronous clear to zero.
module alu_ctrl_rf
  import alu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic [ADDR_W-1:0] rc_addr,
  output logic [DATA_W-1:0] rc_data
);

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];
  assign rc_data = regs[rc_addr];

endmodule

// File: rtl/alu_ctrl.sv
// Sequences one instruction at a time through an external combinational ALU.
// Build option: define ALU_CTRL_REPEAT_EN to honour the rep field (otherwise one EXEC cycle).
module alu_ctrl
  import alu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ins_valid,
  output logic              ins_ready,
  input  logic [DATA_W-1:0] ins_word,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OPC_W-1:0]  alu_opc,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_w,
  input  logic              alu_zer,
  input  logic              alu_neg,
  output logic              done,
  output logic              zero,
  output logic              negative
);

  // Handshake: an instruction transfers on a rising edge where ins_valid && ins_ready;
  // ins_ready is high only in IDLE and does not depend on ins_valid.

  state_e            state, state_nxt;
  ins_t              ins_q;
  logic              accept;
  logic              exec;
  logic              rep_last;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] src_a_data;
  logic [DATA_W-1:0] src_b_data;
  logic              unused_ok;

  assign ins_ready = (state == ST_IDLE);
  assign exec      = (state == ST_EXEC);
  assign accept    = ins_valid && ins_ready;
  assign done      = (state == ST_DONE);

`ifdef ALU_CTRL_REPEAT_EN
  logic [REP_W-1:0] rep_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt <= '0;
    end else if (accept) begin
      rep_cnt <= ins_word[REP_LSB +: REP_W];
    end else if (exec && rep_cnt != '0) begin
      rep_cnt <= rep_cnt - 1'b1;
    end
  end

  assign rep_last  = (rep_cnt == '0);
  assign unused_ok = ^ins_word[RSV_LSB +: RSV_W];
`else
  assign rep_last  = 1'b1;
  assign unused_ok = ^{ins_word[RSV_LSB +: RSV_W], ins_word[REP_LSB +: REP_W]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (accept) state_nxt = ST_EXEC;
      ST_EXEC: if (rep_last) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ins_q <= '0;
    else if (accept) ins_q <= decode_ins(ins_word);
  end

  // Loads share the write port with EXEC; they only reach it in IDLE, so a load on
  // the accept edge lands before the first EXEC read.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = ld_addr;
    rf_wdata = ld_data;
    if (exec) begin
      rf_we    = 1'b1;
      rf_waddr = ins_q.dst;
      rf_wdata = alu_w;
    end else if (ins_ready && ld_valid) begin
      rf_we    = 1'b1;
    end
  end

  alu_ctrl_rf u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .ra_addr (ins_q.src_a),
    .ra_data (src_a_data),
    .rb_addr (ins_q.src_b),
    .rb_data (src_b_data),
    .rc_addr (rd_addr),
    .rc_data (rd_data)
  );

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_opc = ZERO;
    alu_cin = 1'b0;
    if (exec) begin
      alu_a   = src_a_data;
      alu_b   = src_b_data;
      alu_opc = ins_q.opc;
      alu_cin = ins_q.cin;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero     <= 1'b0;
      negative <= 1'b0;
    end else if (exec) begin
      zero     <= alu_zer;
      negative <= alu_neg;
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: behavioural ALU attached to the DUT, instruction-level reference
// model of the register file and flags, directed scenarios then random instructions.
module tb_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ins_valid;
  logic        ins_ready;
  logic [15:0] ins_word;
  logic        ld_valid;
  logic [1:0]  ld_addr;
  logic [15:0] ld_data;
  logic [1:0]  rd_addr;
  logic [15:0] rd_data;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_opc;
  logic        alu_cin;
  logic [15:0] alu_w;
  logic        alu_zer, alu_neg;
  logic        done, zero, negative;

  logic [15:0] ref_r [4];
  logic        ref_z, ref_n;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  alu_ctrl dut (
    .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_word(ins_word),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .alu_a(alu_a), .alu_b(alu_b), .alu_opc(alu_opc), .alu_cin(alu_cin),
    .alu_w(alu_w), .alu_zer(alu_zer), .alu_neg(alu_neg), .done(done), .zero(zero),
    .negative(negative)
  );

  function automatic logic [15:0] alu_fn(input logic [2:0] opc, input logic [15:0] a,
                                         input logic [15:0] b, input logic c);
    logic signed [15:0] half;
    case (opc)
      3'd0: return b + a + {15'd0, c};
      3'd1: begin half = a; half = half >>> 1; return b + half; end
      3'd2: return b + 16'd1;
      3'd3: begin half = b; half = half >>> 1; return b + half; end
      3'd4: return b & a;
      3'd5: return b | a;
      3'd6: return ~b;
      default: return 16'd0;
    endcase
  endfunction

  always_comb alu_w = alu_fn(alu_opc, alu_a, alu_b, alu_cin);
  assign alu_zer = (alu_w == 16'd0);
  assign alu_neg = alu_w[15];

  function automatic logic [15:0] mk(input int opc, input int cin, input int dst,
                                     input int sa, input int sb, input int rep);
    logic [15:0] w;
    w = {2'b00, 4'(rep), 2'(sb), 2'(sa), 2'(dst), 1'(cin), 3'(opc)};
    return w;
  endfunction

  function automatic int rep_eff(input logic [15:0] w);
`ifdef ALU_CTRL_REPEAT_EN
    return int'(w[13:10]);
`else
    return 0;
`endif
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Instruction-level model: rep+1 iterations, each re-reading the current registers.
  task automatic model_exec(input logic [15:0] w);
    logic [15:0] res;
    res = 16'd0;
    for (int i = 0; i <= rep_eff(w); i++) begin
      res = alu_fn(w[2:0], ref_r[w[7:6]], ref_r[w[9:8]], w[3]);
      ref_r[w[5:4]] = res;
    end
    ref_z = (res == 16'd0);
    ref_n = res[15];
  endtask

  task automatic check_regs();
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      check_eq($sformatf("r%0d", i), rd_data, ref_r[i]);
    end
    check_eq("zero", zero, ref_z);
    check_eq("negative", negative, ref_n);
  endtask

  task automatic check_idle_alu();
    check_eq("idle_alu_a", alu_a, 16'd0);
    check_eq("idle_alu_b", alu_b, 16'd0);
    check_eq("idle_alu_opc", alu_opc, 16'd7);
    check_eq("idle_alu_cin", alu_cin, 16'd0);
  endtask

  task automatic load(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk);
    #1 ld_valid = 1'b0;
    ref_r[a] = d;
  endtask

  // Called just after the accepting edge; follows the instruction to its done pulse.
  task automatic track(input logic [15:0] w);
    int n, cyc;
    bit seen;
    logic [15:0] exp_a, exp_b;
    n = rep_eff(w);
    exp_a = ref_r[w[7:6]];
    exp_b = ref_r[w[9:8]];
    model_exec(w);
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check_eq("exec_alu_a", alu_a, exp_a);
        check_eq("exec_alu_b", alu_b, exp_b);
        check_eq("exec_alu_opc", alu_opc, 16'(w[2:0]));
        check_eq("exec_alu_cin", alu_cin, 16'(w[3]));
      end
      if (done) seen = 1;
      else check_eq("ready_busy", ins_ready, 16'd0);
    end
    check_eq("done_seen", 16'(seen), 16'd1);
    check_eq("latency", 16'(cyc), 16'(n + 2));
    @(negedge clk);
    check_eq("done_one_cycle", done, 16'd0);
    check_eq("ready_after", ins_ready, 16'd1);
    check_idle_alu();
    check_regs();
  endtask

  task automatic issue(input logic [15:0] w, input bit ld_en, input logic [1:0] la,
                       input logic [15:0] ld);
    @(negedge clk);
    check_eq("ready_idle", ins_ready, 16'd1);
    ins_valid = 1'b1; ins_word = w;
    ld_valid = ld_en; ld_addr = la; ld_data = ld;
    @(posedge clk);
    #1 ins_valid = 1'b0; ld_valid = 1'b0;
    if (ld_en) ref_r[la] = ld;
    track(w);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] wa, wb, w;
    int cyc;
    bit seen;
    rst = 1'b1; ins_valid = 1'b0; ins_word = '0; ld_valid = 1'b0;
    ld_addr = '0; ld_data = '0; rd_addr = '0;
    for (int i = 0; i < 4; i++) ref_r[i] = 16'd0;
    ref_z = 1'b0; ref_n = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_done", done, 16'd0);
    check_regs();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", ins_ready, 16'd1);
    check_idle_alu();

    // ADD with carry: 5 + 3 + 1
    load(2'd0, 16'd5);
    load(2'd1, 16'd3);
    issue(mk(0, 1, 2, 0, 1, 0), 1'b0, 2'd0, 16'd0);
    check_eq("add_r2", ref_r[2], 16'd9);

    // NOT of zero
    load(2'd0, 16'd0);
    issue(mk(6, 0, 3, 0, 0, 0), 1'b0, 2'd0, 16'd0);
    check_eq("not_r3", ref_r[3], 16'hFFFF);

    // INC accumulating into itself with rep=4
    load(2'd1, 16'd0);
    issue(mk(2, 0, 1, 0, 1, 4), 1'b0, 2'd0, 16'd0);
`ifdef ALU_CTRL_REPEAT_EN
    check_eq("inc_rep_r1", ref_r[1], 16'd5);
`else
    check_eq("inc_norep_r1", ref_r[1], 16'd1);
`endif

    // ins_valid held through an instruction; ld_valid during EXEC ignored
    wa = mk(4, 0, 2, 3, 1, 1);
    wb = mk(5, 1, 0, 2, 3, 0);
    @(negedge clk);
    ins_valid = 1'b1; ins_word = wa;
    @(posedge clk);
    model_exec(wa);
    cyc = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      check_eq("held_ready_busy", ins_ready, 16'd0);
      if (cyc == 1) begin
        ld_valid = 1'b1; ld_addr = 2'd3; ld_data = 16'(~ref_r[3]);
      end
      if (done) begin
        seen = 1; ld_valid = 1'b0; ins_word = wb;
      end
    end
    check_eq("held_latency", 16'(cyc), 16'(rep_eff(wa) + 2));
    @(negedge clk);
    check_eq("held_ready_idle", ins_ready, 16'd1);
    check_eq("held_done_low", done, 16'd0);
    check_regs();
    @(posedge clk);
    #1 ins_valid = 1'b0;
    track(wb);

    // Reset during EXEC of a rep=3 instruction
    load(2'd0, 16'h0101);
    load(2'd1, 16'h0202);
    @(negedge clk);
    ins_valid = 1'b1; ins_word = mk(0, 1, 1, 1, 0, 3);
    @(posedge clk);
    #1 ins_valid = 1'b0;
    @(negedge clk);
`ifdef ALU_CTRL_REPEAT_EN
    @(negedge clk);
`endif
    rst = 1'b1;
    #1;
    check_eq("rst_exec_done", done, 16'd0);
    check_eq("rst_exec_ready", ins_ready, 16'd1);
    for (int i = 0; i < 4; i++) ref_r[i] = 16'd0;
    ref_z = 1'b0; ref_n = 1'b0;
    check_regs();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("post_rst_done", done, 16'd0);
      check_eq("post_rst_ready", ins_ready, 16'd1);
    end
    check_regs();

    // ZERO opcode
    load(2'd2, 16'h1234);
    issue(mk(7, 0, 2, 0, 0, 0), 1'b0, 2'd0, 16'd0);
    check_eq("zero_r2", ref_r[2], 16'd0);

    // Random instructions, sometimes with a load on the accepting edge
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) load(2'($urandom_range(0, 3)), 16'($urandom));
      w = 16'($urandom);
      if ($urandom_range(0, 1) == 1) w[13:12] = 2'b00;
      issue(w, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
